// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES datapath (IP, 16 Feistel rounds, FP).
// Takes one 64-bit block per in_valid/in_ready handshake and presents the
// result on data_out with out_valid held until out_ready. The 16 round keys
// arrive on one packed bus and are always applied in index order 1..16.
// Encrypt or decrypt is decided only by the key order upstream presents.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   data_in valid
//   in_ready   engine can accept a block this cycle
//   data_in    64-bit block, bit 63 = DES bit 1
//   roundkeys  roundkey_1 at [767:720] ... roundkey_16 at [47:0]
//   out_valid  data_out valid, held until taken
//   out_ready  consumer accepts data_out
//   data_out   64-bit result, bit 63 = DES bit 1
//   busy       high while rounds are in progress
//
// Parameter ROUNDS_PER_CYCLE (1,2,4,8,16): Feistel rounds chained per clock.
// Macro DES_KEY_LATCH_EN: when defined, roundkeys is captured on each accept
// edge and the rounds use that copy; otherwise the live bus is used and must
// stay stable from the accept edge through the final round edge.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// ROUND | applying ROUNDS_PER_CYCLE rounds per edge
// DONE  | result held on data_out, out_valid=1
module des_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic [767:0] roundkeys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $fatal(1, "des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Tables use DES 1-based bit numbering, bit 1 = MSB.
  localparam logic [6:0] IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam logic [6:0] FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam logic [6:0] E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam logic [6:0] P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Each S-box: 64 nibbles, entry (row*16+col) at the MSB end first.
  localparam logic [255:0] S_T [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(IP_T[i]))];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(FP_T[i]))];
    return y;
  endfunction

  function automatic logic [3:0] sbox_f(input logic [2:0] n, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};   // row = outer bits, col = inner four
    return S_T[n][8'(255 - 4 * int'(idx)) -: 4];
  endfunction

  function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    e = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - int'(E_T[i]))];
    e = e ^ k;
    for (int n = 0; n < 8; n++)
      s[5'(31 - 4 * n) -: 4] = sbox_f(3'(n), e[6'(47 - 6 * n) -: 6]);
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - int'(P_T[i]))];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  l_q, r_q, l_c, r_c, tmp_c;
  logic [4:0]   round_cnt_q;
  logic [63:0]  data_out_q;
  logic [767:0] keys_used;
  logic [47:0]  key_arr [0:15];
  logic [3:0]   kidx;
  logic         accept, last_step;

`ifdef DES_KEY_LATCH_EN
  logic [767:0] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         key_q <= '0;
    else if (accept) key_q <= roundkeys;
  end

  assign keys_used = key_q;
`else
  assign keys_used = roundkeys;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_keys
    assign key_arr[g] = keys_used[767 - 48 * g -: 48];
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND);
  assign data_out  = data_out_q;
  assign last_step = (round_cnt_q + 5'(ROUNDS_PER_CYCLE)) == 5'd16;

  // Chained Feistel rounds for one clock.
  always_comb begin
    l_c   = l_q;
    r_c   = r_q;
    tmp_c = '0;
    kidx  = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      kidx  = round_cnt_q[3:0] + 4'(j);
      tmp_c = r_c;
      r_c   = l_c ^ f_f(r_c, key_arr[kidx]);
      l_c   = tmp_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ROUND;
      ROUND:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q         <= '0;
      r_q         <= '0;
      round_cnt_q <= '0;
      data_out_q  <= '0;
    end else if (accept) begin
      {l_q, r_q}  <= ip_f(data_in);
      round_cnt_q <= '0;
    end else if (state_q == ROUND) begin
      l_q         <= l_c;
      r_q         <= r_c;
      round_cnt_q <= round_cnt_q + 5'(ROUNDS_PER_CYCLE);
      // Halves are swapped back before FP after round 16.
      if (last_step) data_out_q <= fp_f({r_c, l_c});
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]   in_valid_v, out_ready_v, in_ready_v, out_valid_v, busy_v;
  logic [63:0]  data_in_v  [2];
  logic [63:0]  data_out_v [2];
  logic [767:0] rk_v       [2];
  logic [767:0] k1e, k1d, k2e;
  int checks   = 0;
  int failures = 0;
  int lat_v [2] = '{16, 4};

  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_round_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .data_in(data_in_v[0]), .roundkeys(rk_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .data_out(data_out_v[0]), .busy(busy_v[0]));

  des_round_engine #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .data_in(data_in_v[1]), .roundkeys(rk_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .data_out(data_out_v[1]), .busy(busy_v[1]));

  // Standard DES key schedule; decr places K16 in slot 1 ... K1 in slot 16.
  function automatic logic [767:0] make_keys(input logic [63:0] key, input bit decr);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    logic [767:0] bus;
    int slot;
    cd = '0;
    k = '0;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    bus = '0;
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_T[i]];
      slot = decr ? 15 - r : r;
      bus[767 - 48 * slot -: 48] = k;
    end
    return bus;
  endfunction

  task automatic start(input int sel, input logic [767:0] keys, input logic [63:0] din);
    rk_v[sel] = keys;
    data_in_v[sel] = din;
    in_valid_v[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[sel] = 1'b0;
    data_in_v[sel] = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (!out_valid_v[sel] && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    in_valid_v = '0;
    out_ready_v = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (in_ready_v[s] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d]: got %b want 1", s, in_ready_v[s]); end
      checks++; if (out_valid_v[s] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, out_valid_v[s]); end
      checks++; if (busy_v[s] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_v[s]); end
      checks++; if (data_out_v[s] !== 64'h0) begin failures++; $display("FAIL reset_data_out[%0d]: got %h want 0", s, data_out_v[s]); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (in_ready_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin failures++; $display("FAIL post_reset_idle[%0d]: in_ready=%b busy=%b want 1/0", s, in_ready_v[s], busy_v[s]); end
    end
  endtask

  task automatic test_vector(input int sel, input string nm, input logic [767:0] keys,
                             input logic [63:0] din, input logic [63:0] exp);
    int cyc;
    start(sel, keys, din);
    checks++; if (busy_v[sel] !== 1'b1 || in_ready_v[sel] !== 1'b0) begin failures++; $display("FAIL %s_after_accept[%0d]: busy=%b in_ready=%b want 1/0", nm, sel, busy_v[sel], in_ready_v[sel]); end
    wait_done(sel, cyc);
    checks++; if (cyc !== lat_v[sel]) begin failures++; $display("FAIL %s_latency[%0d]: got %0d want %0d", nm, sel, cyc, lat_v[sel]); end
    checks++; if (data_out_v[sel] !== exp) begin failures++; $display("FAIL %s_data[%0d]: got %h want %h", nm, sel, data_out_v[sel], exp); end
    checks++; if (busy_v[sel] !== 1'b0 || in_ready_v[sel] !== 1'b0) begin failures++; $display("FAIL %s_done_flags[%0d]: busy=%b in_ready=%b want 0/0", nm, sel, busy_v[sel], in_ready_v[sel]); end
    out_ready_v[sel] = 1'b1;
    #1;
    checks++; if (in_ready_v[sel] !== 1'b1) begin failures++; $display("FAIL %s_ready_on_take[%0d]: got %b want 1", nm, sel, in_ready_v[sel]); end
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
    checks++; if (out_valid_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0 || in_ready_v[sel] !== 1'b1) begin failures++; $display("FAIL %s_back_to_idle[%0d]: out_valid=%b busy=%b in_ready=%b want 0/0/1", nm, sel, out_valid_v[sel], busy_v[sel], in_ready_v[sel]); end
  endtask

  task automatic test_back_to_back(input int sel);
    int cyc;
    start(sel, k1e, P1);
    wait_done(sel, cyc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid_v[sel] !== 1'b1 || data_out_v[sel] !== C1 || in_ready_v[sel] !== 1'b0) begin failures++; $display("FAIL backpressure_hold[%0d] cyc %0d: out_valid=%b data=%h in_ready=%b want 1/%h/0", sel, k, out_valid_v[sel], data_out_v[sel], in_ready_v[sel], C1); end
    end
    out_ready_v[sel] = 1'b1;
    in_valid_v[sel] = 1'b1;
    rk_v[sel] = k2e;
    data_in_v[sel] = P2;
    #1;
    checks++; if (in_ready_v[sel] !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", sel, in_ready_v[sel]); end
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
    in_valid_v[sel] = 1'b0;
    data_in_v[sel] = {$urandom, $urandom};
    checks++; if (out_valid_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin failures++; $display("FAIL b2b_accept[%0d]: out_valid=%b busy=%b want 0/1", sel, out_valid_v[sel], busy_v[sel]); end
    wait_done(sel, cyc);
    checks++; if (cyc !== lat_v[sel]) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", sel, cyc, lat_v[sel]); end
    checks++; if (data_out_v[sel] !== C2) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", sel, data_out_v[sel], C2); end
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
  endtask

  task automatic test_reset_mid(input int sel);
    int seen;
    start(sel, k1e, P1);
    repeat (sel == 0 ? 6 : 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++; if (busy_v[sel] !== 1'b0 || in_ready_v[sel] !== 1'b1 || out_valid_v[sel] !== 1'b0) begin failures++; $display("FAIL midreset_async[%0d]: busy=%b in_ready=%b out_valid=%b want 0/1/0", sel, busy_v[sel], in_ready_v[sel], out_valid_v[sel]); end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (out_valid_v[sel]) seen++; end
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid_v[sel] || busy_v[sel]) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_output[%0d]: got %0d active cycles want 0", sel, seen); end
    checks++; if (in_ready_v[sel] !== 1'b1) begin failures++; $display("FAIL midreset_in_ready[%0d]: got %b want 1", sel, in_ready_v[sel]); end
    test_vector(sel, "after_reset", k1e, P1, C1);
  endtask

  task automatic test_key_hold(input int sel);
    int cyc;
    start(sel, k1e, P1);
`ifdef DES_KEY_LATCH_EN
    @(posedge clk); #1;
    rk_v[sel] = ~k1e;
`endif
    wait_done(sel, cyc);
    checks++; if (data_out_v[sel] !== C1) begin failures++; $display("FAIL keyhold_data[%0d]: got %h want %h", sel, data_out_v[sel], C1); end
    rk_v[sel] = ~k1e;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_out_v[sel] !== C1 || out_valid_v[sel] !== 1'b1) begin failures++; $display("FAIL done_stable[%0d]: data=%h out_valid=%b want %h/1", sel, data_out_v[sel], out_valid_v[sel], C1); end
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid_v = '0;
    out_ready_v = '0;
    data_in_v[0] = '0;
    data_in_v[1] = '0;
    rk_v[0] = '0;
    rk_v[1] = '0;
    k1e = make_keys(64'h133457799BBCDFF1, 1'b0);
    k1d = make_keys(64'h133457799BBCDFF1, 1'b1);
    k2e = make_keys(64'h0E329232EA6D0D73, 1'b0);
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_vector(s, "encrypt", k1e, P1, C1);
      test_vector(s, "decrypt", k1d, C1, P1);
      test_vector(s, "vector2", k2e, P2, C2);
      test_back_to_back(s);
      test_reset_mid(s);
      test_key_hold(s);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
